// File: rtl/mib_mem_req_bridge.sv
// mib_mem_req_bridge: queues local 128-bit requests and issues them
// on the PPC440 MIB command port, returning read data in order.
module mib_mem_req_bridge #(
  parameter int          C_FIFO_DEPTH      = 4,
  parameter int          C_MAX_OUTSTANDING = 4,
  parameter logic [31:0] C_MEM_BASEADDR    = 32'h00000000,
  parameter logic [31:0] C_MEM_HIGHADDR    = 32'h0fffffff
) (
  input  logic          mc_mibclk,
  input  logic          mi_mcreset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rnw,
  input  logic [31:0]   req_addr,
  input  logic [15:0]   req_be,
  input  logic [127:0]  req_wdata,
  output logic          rsp_valid,
  output logic [127:0]  rsp_data,
  output logic          rsp_err,
  output logic          addr_err,
  output logic          unexp_rd,
  output logic          mi_mcaddressvalid,
  output logic [0:35]   mi_mcaddress,
  output logic          mi_mcbankconflict,
  output logic          mi_mcrowconflict,
  output logic [0:15]   mi_mcbyteenable,
  output logic [0:127]  mi_mcwritedata,
  output logic          mi_mcreadnotwrite,
  output logic          mi_mcwritedatavalid,
  input  logic          mc_miaddrreadytoaccept,
  input  logic [0:127]  mc_mireaddata,
  input  logic          mc_mireaddataerr,
  input  logic          mc_mireaddatavalid
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(C_FIFO_DEPTH);
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);
  localparam logic [3:0]  LP_MAX   = 4'(C_MAX_OUTSTANDING);

  typedef struct packed {
    logic         rnw;
    logic [31:0]  addr;
    logic [15:0]  be;
    logic [127:0] wdata;
  } ent_t;

  typedef enum logic {S_IDLE, S_ISSUE} st_t;

  ent_t          r_mem [C_FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          r_ready, r_aerr;
  st_t           r_st, w_st_nxt;
  logic [3:0]    r_out;
  logic          r_av, r_rnw;
  logic [31:0]   r_addr;
  logic [15:0]   r_be;
  logic [127:0]  r_wd;
  logic          r_rv, r_rerr, r_unexp;
  logic [127:0]  r_rdata;

  logic          w_acc, w_in_rng, w_push, w_pop;
  logic          w_load, w_sel_nxt;
  logic          w_inc, w_dec, w_head_ok, w_nxt_ok;
  logic [32:0]   w_lo, w_hi;
  logic [AW:0]   w_cnt_nxt;
  logic [3:0]    w_out_nxt;
  ent_t          w_in_ent, w_head, w_next, w_ld_ent;

  assign w_acc    = req_valid & r_ready;
  assign w_lo     = {1'b0, req_addr} - {1'b0, C_MEM_BASEADDR};
  assign w_hi     = {1'b0, C_MEM_HIGHADDR} - {1'b0, req_addr};
  assign w_in_rng = ~w_lo[32] & ~w_hi[32];
  assign w_push   = w_acc & w_in_rng;
  assign w_in_ent = '{rnw: req_rnw, addr: {req_addr[31:4], 4'h0},
                      be: req_be, wdata: req_wdata};

  assign w_head = r_mem[r_rd];
  assign w_next = r_mem[r_rd + 1'b1];
  assign w_pop  = (r_st == S_ISSUE) & mc_miaddrreadytoaccept;
  assign w_inc  = w_pop & r_rnw;
  assign w_dec  = mc_mireaddatavalid & (r_out != 4'd0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_comb begin
    w_out_nxt = r_out;
    unique case ({w_inc, w_dec})
      2'b10:   w_out_nxt = r_out + 1'b1;
      2'b01:   w_out_nxt = r_out - 1'b1;
      default: w_out_nxt = r_out;
    endcase
  end

  // follow-on head must already sit in the FIFO and respect the updated read count
  assign w_head_ok = ~w_head.rnw | (r_out < LP_MAX);
  assign w_nxt_ok  = (r_cnt > LP_ONE) & (~w_next.rnw | (w_out_nxt < LP_MAX));

  always_comb begin
    w_st_nxt  = r_st;
    w_load    = 1'b0;
    w_sel_nxt = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if ((r_cnt != '0) && w_head_ok) begin
          w_st_nxt = S_ISSUE;
          w_load   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (mc_miaddrreadytoaccept) begin
          if (w_nxt_ok) begin
            w_load    = 1'b1;
            w_sel_nxt = 1'b1;
          end else begin
            w_st_nxt = S_IDLE;
          end
        end
      end
      default: w_st_nxt = S_IDLE;
    endcase
  end

  assign w_ld_ent = w_sel_nxt ? w_next : w_head;

  always_ff @(posedge mc_mibclk) begin
    if (w_push) r_mem[r_wr] <= w_in_ent;
  end

  always_ff @(posedge mc_mibclk) begin
    if (mi_mcreset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_aerr  <= 1'b0;
      r_st    <= S_IDLE;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt != LP_DEPTH);
      r_aerr  <= w_acc & ~w_in_rng;
      r_st    <= w_st_nxt;
    end
  end

  always_ff @(posedge mc_mibclk) begin
    if (mi_mcreset) begin
      r_av   <= 1'b0;
      r_rnw  <= 1'b0;
      r_addr <= '0;
      r_be   <= '0;
      r_wd   <= '0;
    end else if (w_load) begin
      r_av   <= 1'b1;
      r_rnw  <= w_ld_ent.rnw;
      r_addr <= w_ld_ent.addr;
      r_be   <= w_ld_ent.rnw ? 16'hFFFF : w_ld_ent.be;
      r_wd   <= w_ld_ent.wdata;
    end else if (w_pop) begin
      r_av <= 1'b0;
    end
  end

  always_ff @(posedge mc_mibclk) begin
    if (mi_mcreset) begin
      r_out   <= '0;
      r_rv    <= 1'b0;
      r_rerr  <= 1'b0;
      r_rdata <= '0;
      r_unexp <= 1'b0;
    end else begin
      r_out  <= w_out_nxt;
      r_rv   <= w_dec;
      r_rerr <= w_dec & mc_mireaddataerr;
      if (w_dec) r_rdata <= mc_mireaddata;
      if (mc_mireaddatavalid && (r_out == 4'd0)) r_unexp <= 1'b1;
    end
  end

  assign req_ready           = r_ready;
  assign addr_err            = r_aerr;
  assign unexp_rd            = r_unexp;
  assign rsp_valid           = r_rv;
  assign rsp_err             = r_rerr;
  assign rsp_data            = r_rdata;
  assign mi_mcaddressvalid   = r_av;
  assign mi_mcaddress        = {4'h0, r_addr};
  assign mi_mcbankconflict   = 1'b0;
  assign mi_mcrowconflict    = 1'b0;
  assign mi_mcbyteenable     = r_be;
  assign mi_mcwritedata      = r_wd;
  assign mi_mcreadnotwrite   = r_rnw;
  assign mi_mcwritedatavalid = r_av & ~r_rnw;

endmodule

// File: tb/tb_mib_mem_req_bridge.sv
// tb_mib_mem_req_bridge: directed vector table plus hand sequences
// for the MIB request bridge.
module tb_mib_mem_req_bridge;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_rnw;
  logic [31:0]   req_addr;
  logic [15:0]   req_be;
  logic [127:0]  req_wdata;
  logic          rsp_valid, rsp_err, addr_err, unexp_rd;
  logic [127:0]  rsp_data;
  logic          mi_mcaddressvalid, mi_mcbankconflict, mi_mcrowconflict;
  logic [0:35]   mi_mcaddress;
  logic [0:15]   mi_mcbyteenable;
  logic [0:127]  mi_mcwritedata;
  logic          mi_mcreadnotwrite, mi_mcwritedatavalid;
  logic          mrdy;
  logic [0:127]  rdata;
  logic          rerr, rdv;

  always #5 clk = ~clk;

  mib_mem_req_bridge dut (
    .mc_mibclk              (clk),
    .mi_mcreset             (rst),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_rnw                (req_rnw),
    .req_addr               (req_addr),
    .req_be                 (req_be),
    .req_wdata              (req_wdata),
    .rsp_valid              (rsp_valid),
    .rsp_data               (rsp_data),
    .rsp_err                (rsp_err),
    .addr_err               (addr_err),
    .unexp_rd               (unexp_rd),
    .mi_mcaddressvalid      (mi_mcaddressvalid),
    .mi_mcaddress           (mi_mcaddress),
    .mi_mcbankconflict      (mi_mcbankconflict),
    .mi_mcrowconflict       (mi_mcrowconflict),
    .mi_mcbyteenable        (mi_mcbyteenable),
    .mi_mcwritedata         (mi_mcwritedata),
    .mi_mcreadnotwrite      (mi_mcreadnotwrite),
    .mi_mcwritedatavalid    (mi_mcwritedatavalid),
    .mc_miaddrreadytoaccept (mrdy),
    .mc_mireaddata          (rdata),
    .mc_mireaddataerr       (rerr),
    .mc_mireaddatavalid     (rdv)
  );

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [127:0] WD = 128'h0123456789ABCDEF0123456789ABCDEF;

  typedef struct {
    logic        v, rnw;
    logic [31:0] addr;
    logic [15:0] be;
    logic        mrdy, rdv, rerr;
    logic        e_rdy, e_av, e_wdv, e_rnw;
    logic [31:0] e_addr;
    logic [15:0] e_be;
    logic        e_rspv, e_err, e_aerr, e_unexp;
  } vec_t;

  vec_t tbl [11];
  int n_chk = 0;
  int n_err = 0;
  int n_x = 0;
  logic [31:0] xa [64];

  // transfer log: command accepted by the MC this cycle
  always @(posedge clk) begin
    if (!rst && mi_mcaddressvalid && mrdy) begin
      if (n_x < 64) xa[n_x] <= mi_mcaddress[4:35];
      n_x <= n_x + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0;
    mrdy = 1'b0; rdv = 1'b0; rerr = 1'b0; rdata = '0;
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_av", mi_mcaddressvalid, 0);
    chk("rst_wdv", mi_mcwritedatavalid, 0);
    chk("rst_addr", mi_mcaddress, 0);
    chk("rst_be", mi_mcbyteenable, 0);
    chk("rst_wd", mi_mcwritedata, 0);
    chk("rst_rnw", mi_mcreadnotwrite, 0);
    chk("rst_conf", {mi_mcbankconflict, mi_mcrowconflict}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, addr_err, unexp_rd}, 0);
    chk("rst_rdata", rsp_data, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready_after", req_ready, 1);
  endtask

  task automatic push(input logic rnw, input logic [31:0] a,
                      input logic [15:0] be, input logic [127:0] wd);
    logic acc;
    logic ok;
    ok = 1'b0;
    req_valid = 1'b1; req_rnw = rnw; req_addr = a;
    req_be = be; req_wdata = wd;
    for (int k = 0; k < 20; k++) begin
      acc = req_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    chk("push_accept", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [31:0] ba [4];
    logic [15:0] bb [4];
    logic [127:0] bw [4];
    logic [127:0] dd;
    vec_t t;

    tbl[0]  = '{Y,N,32'h100,16'h0FF0,Y,N,N, Y,N,N,N,32'h0,16'h0,N,N,N,N};
    tbl[1]  = '{N,N,32'h0,16'h0,Y,N,N, Y,Y,Y,N,32'h100,16'h0FF0,N,N,N,N};
    tbl[2]  = '{Y,Y,32'h10000000,16'h0,Y,N,N, Y,N,N,N,32'h0,16'h0,N,N,Y,N};
    tbl[3]  = '{Y,Y,32'h200,16'h0001,Y,N,N, Y,N,N,N,32'h0,16'h0,N,N,N,N};
    tbl[4]  = '{N,N,32'h0,16'h0,Y,N,N, Y,Y,N,Y,32'h200,16'hFFFF,N,N,N,N};
    tbl[5]  = '{N,N,32'h0,16'h0,Y,N,N, Y,N,N,N,32'h0,16'h0,N,N,N,N};
    tbl[6]  = '{N,N,32'h0,16'h0,Y,Y,Y, Y,N,N,N,32'h0,16'h0,Y,Y,N,N};
    tbl[7]  = '{N,N,32'h0,16'h0,Y,Y,N, Y,N,N,N,32'h0,16'h0,N,N,N,Y};
    tbl[8]  = '{Y,N,32'h0FFFFFF0,16'hFFFF,Y,N,N, Y,N,N,N,32'h0,16'h0,N,N,N,Y};
    tbl[9]  = '{N,N,32'h0,16'h0,Y,N,N, Y,Y,Y,N,32'h0FFFFFF0,16'hFFFF,N,N,N,Y};
    tbl[10] = '{N,N,32'h0,16'h0,Y,N,N, Y,N,N,N,32'h0,16'h0,N,N,N,Y};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      t = tbl[i];
      req_valid = t.v; req_rnw = t.rnw; req_addr = t.addr;
      req_be = t.be; req_wdata = WD;
      mrdy = t.mrdy; rdv = t.rdv; rerr = t.rerr;
      rdata = {4{32'hC0DE0000 | 32'(i)}};
      tick();
      chk($sformatf("v%0d_ready", i), req_ready, t.e_rdy);
      chk($sformatf("v%0d_av", i), mi_mcaddressvalid, t.e_av);
      chk($sformatf("v%0d_wdv", i), mi_mcwritedatavalid, t.e_wdv);
      chk($sformatf("v%0d_rspv", i), rsp_valid, t.e_rspv);
      chk($sformatf("v%0d_aerr", i), addr_err, t.e_aerr);
      chk($sformatf("v%0d_unexp", i), unexp_rd, t.e_unexp);
      if (t.e_av) begin
        chk($sformatf("v%0d_addr", i), mi_mcaddress, {4'h0, t.e_addr});
        chk($sformatf("v%0d_rnw", i), mi_mcreadnotwrite, t.e_rnw);
        chk($sformatf("v%0d_be", i), mi_mcbyteenable, t.e_be);
      end
      if (t.e_wdv) chk($sformatf("v%0d_wd", i), mi_mcwritedata, WD);
      if (t.e_rspv) begin
        chk($sformatf("v%0d_rdata", i), rsp_data, {4{32'hC0DE0000 | 32'(i)}});
        chk($sformatf("v%0d_rerr", i), rsp_err, t.e_err);
      end
    end
    req_valid = 1'b0; rdv = 1'b0; rerr = 1'b0;

    // four writes queued while the MC is stalled, then drained back-to-back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ba[i] = 32'h1000 + 32'(i * 16);
      bb[i] = 16'h8001 ^ 16'(i << 4);
      bw[i] = {4{32'hD0000000 + 32'(i)}};
      push(1'b0, ba[i], bb[i], bw[i]);
    end
    chk("b_full_ready", req_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b_hold_av", mi_mcaddressvalid, 1);
      chk("b_hold_addr", mi_mcaddress, {4'h0, ba[0]});
      chk("b_hold_be", mi_mcbyteenable, bb[0]);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b%0d_av", i), mi_mcaddressvalid, 1);
      chk($sformatf("b%0d_wdv", i), mi_mcwritedatavalid, 1);
      chk($sformatf("b%0d_addr", i), mi_mcaddress, {4'h0, ba[i]});
      chk($sformatf("b%0d_be", i), mi_mcbyteenable, bb[i]);
      chk($sformatf("b%0d_wd", i), mi_mcwritedata, bw[i]);
      if (i == 0) chk("b_full_pop_ready", req_ready, 0);
      if (i == 1) chk("b_after_pop_ready", req_ready, 1);
      mrdy = 1'b1;
      tick();
    end
    chk("b_drained_av", mi_mcaddressvalid, 0);
    mrdy = 1'b0;

    // six reads against an outstanding limit of four
    do_reset();
    base = n_x;
    mrdy = 1'b1;
    for (int i = 0; i < 6; i++)
      push(1'b1, 32'h2000 + 32'(i * 16), 16'h0, '0);
    repeat (8) tick();
    chk("c_limit_xfers", n_x - base, 4);
    dd = {4{32'hBEEF0000}};
    rdv = 1'b1; rdata = dd;
    tick();
    rdv = 1'b0;
    chk("c_rsp0_v", rsp_valid, 1);
    chk("c_rsp0_d", rsp_data, dd);
    repeat (6) tick();
    chk("c_fifth_xfer", n_x - base, 5);
    for (int j = 1; j < 6; j++) begin
      dd = {4{32'hBEEF0000 + 32'(j)}};
      rdv = 1'b1; rdata = dd;
      tick();
      rdv = 1'b0;
      chk($sformatf("c_rsp%0d_v", j), rsp_valid, 1);
      chk($sformatf("c_rsp%0d_d", j), rsp_data, dd);
      tick();
      chk($sformatf("c_rsp%0d_gap", j), rsp_valid, 0);
    end
    chk("c_total_xfers", n_x - base, 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("c_order%0d", k), xa[base + k], 32'h2000 + 32'(k * 16));
    chk("c_no_unexp", unexp_rd, 0);
    mrdy = 1'b0;

    // read transfer coinciding with a return at count 2
    do_reset();
    for (int i = 0; i < 3; i++)
      push(1'b1, 32'h5000 + 32'(i * 16), 16'h0, '0);
    for (int k = 0; k < 10 && !mi_mcaddressvalid; k++) tick();
    chk("d_av", mi_mcaddressvalid, 1);
    mrdy = 1'b1;
    tick();
    tick();
    mrdy = 1'b0;
    chk("d_third_held", mi_mcaddress, {4'h0, 32'h5020});
    mrdy = 1'b1; rdv = 1'b1; rdata = {4{32'h11111111}};
    tick();
    mrdy = 1'b0;
    chk("d_coinc_rspv", rsp_valid, 1);
    chk("d_coinc_av", mi_mcaddressvalid, 0);
    tick();
    chk("d_beat2_rspv", rsp_valid, 1);
    tick();
    chk("d_beat3_rspv", rsp_valid, 1);
    chk("d_beat3_unexp", unexp_rd, 0);
    tick();
    rdv = 1'b0;
    chk("d_beat4_rspv", rsp_valid, 0);
    chk("d_beat4_unexp", unexp_rd, 1);
    tick();
    chk("d_unexp_sticky", unexp_rd, 1);

    // reset with reads in flight and writes still queued
    do_reset();
    base = n_x;
    mrdy = 1'b1;
    push(1'b1, 32'h3000, 16'h0, '0);
    push(1'b1, 32'h3010, 16'h0, '0);
    for (int k = 0; k < 10 && (n_x - base) < 2; k++) tick();
    chk("e_two_out", n_x - base, 2);
    mrdy = 1'b0;
    for (int i = 0; i < 3; i++)
      push(1'b0, 32'h4000 + 32'(i * 16), 16'hFFFF, WD);
    tick();
    chk("e_pending_av", mi_mcaddressvalid, 1);
    do_reset();
    base = n_x;
    mrdy = 1'b1;
    repeat (4) tick();
    chk("e_fifo_empty", n_x - base, 0);
    rdv = 1'b1; rdata = {4{32'h22222222}};
    tick();
    rdv = 1'b0;
    chk("e_cnt0_rspv", rsp_valid, 0);
    chk("e_cnt0_unexp", unexp_rd, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
